// File: rtl/calc2_pkg.sv
// calc2_pkg: shared types and helpers for the calc2 calculator.
//   cmd_e    - command encodings carried on reqN_cmd_in
//   resp_e   - response codes driven on out_respN
//   req_t    - one complete request {cmd, tag, op1, op2} as held in a port FIFO
//   result_t - ALU output {resp, data}
//   alu()    - single shared ALU, unsigned 32-bit
package calc2_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    localparam int unsigned FifoDepth = 4;

    // cmd stays raw 4-bit so invalid codes survive until the ALU flags them.
    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } req_t;

    typedef struct packed {
        resp_e       resp;
        logic [31:0] data;
    } result_t;

    // Data is forced to 0 on every error path.
    function automatic result_t alu(input req_t r);
        result_t     res;
        logic [32:0] sum;
        res.resp = RESP_ERR;
        res.data = '0;
        sum      = {1'b0, r.op1} + {1'b0, r.op2};
        case (r.cmd)
            CMD_ADD: begin
                if (!sum[32]) begin
                    res.resp = RESP_OK;
                    res.data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (r.op2 <= r.op1) begin
                    res.resp = RESP_OK;
                    res.data = r.op1 - r.op2;
                end
            end
            CMD_SHL: begin
                res.resp = RESP_OK;
                res.data = r.op1 << r.op2[4:0];
            end
            CMD_SHR: begin
                res.resp = RESP_OK;
                res.data = r.op1 >> r.op2[4:0];
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calc2_if.sv
// calc2_if: request/response bundle of the four calculator ports.
//   reqN_cmd_in/reqN_data_in/reqN_tag_in - request inputs of port N
//   out_respN/out_dataN/out_tagN         - tagged response of port N
// Modports: master (requester side), slave (calculator side).
interface calc2_if;

    logic [3:0]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
    logic [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [1:0]  req1_tag_in,  req2_tag_in,  req3_tag_in,  req4_tag_in;
    logic [1:0]  out_resp1,    out_resp2,    out_resp3,    out_resp4;
    logic [31:0] out_data1,    out_data2,    out_data3,    out_data4;
    logic [1:0]  out_tag1,     out_tag2,     out_tag3,     out_tag4;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4,
        input  out_tag1, out_tag2, out_tag3, out_tag4
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4,
        output out_tag1, out_tag2, out_tag3, out_tag4
    );

endinterface

// File: rtl/calc2_port.sv
// calc2_port: per-port request capture FSM plus in-order request FIFO.
//   c_clk, reset - clock, asynchronous active-low reset
//   cmd/data/tag - raw request inputs of this port
//   pop          - arbiter grant; consumes the presented head this edge
//   head_valid   - a request is available for dispatch
//   head         - oldest pending request
// A request whose op2 is on the inputs this cycle is already presented as the
// head when the FIFO is empty, so an uncontended request is dispatched at the
// same edge that would otherwise write it into the FIFO.
module calc2_port
    import calc2_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  cmd,
    input  logic [31:0] data,
    input  logic [1:0]  tag,
    input  logic        pop,
    output logic        head_valid,
    output req_t        head
);

    localparam int unsigned     PtrW      = $clog2(FifoDepth);
    localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FifoDepth);

    typedef enum logic {StIdle, StWaitOp2} state_e;

    state_e            state_q;
    logic [3:0]        cmd_q;
    logic [1:0]        tag_q;
    logic [31:0]       op1_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    req_t              mem_q [FifoDepth];

    logic   empty, in_flight, bypass, pop_fifo, push;
    req_t   incoming;

    assign empty     = (count_q == '0);
    assign in_flight = (state_q == StWaitOp2);
    assign incoming  = '{cmd: cmd_q, tag: tag_q, op1: op1_q, op2: data};

    assign head_valid = !empty || in_flight;
    assign head       = empty ? incoming : mem_q[rd_ptr_q];

    assign bypass   = pop && empty && in_flight;
    assign pop_fifo = pop && !empty;
    // A full FIFO still accepts the new entry when its head leaves this edge.
    assign push     = in_flight && !bypass && ((count_q != FullCount) || pop_fifo);

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            tag_q    <= '0;
            op1_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd != '0) begin
                        state_q <= StWaitOp2;
                        cmd_q   <= cmd;
                        tag_q   <= tag;
                        op1_q   <= data;
                    end
                end
                StWaitOp2: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
            if (push)     wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_fifo) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop_fifo);
        end
    end

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge c_clk) begin
        if (push) mem_q[wr_ptr_q] <= incoming;
    end

endmodule

// File: rtl/calc2_top.sv
// calc2_top: four-port tagged 32-bit calculator sharing one ALU.
//   c_clk - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - calc2_if.slave: per-port requests in, registered tagged responses out
// Four calc2_port instances feed a round-robin arbiter; the granted head goes
// through the ALU and is registered onto its port's outputs for one cycle.
module calc2_top
    import calc2_pkg::*;
(
    input  logic    c_clk,
    input  logic    reset,
    calc2_if.slave  bus
);

    logic [3:0]  cmd  [4];
    logic [31:0] data [4];
    logic [1:0]  tag  [4];

    assign cmd[0]  = bus.req1_cmd_in;
    assign cmd[1]  = bus.req2_cmd_in;
    assign cmd[2]  = bus.req3_cmd_in;
    assign cmd[3]  = bus.req4_cmd_in;
    assign data[0] = bus.req1_data_in;
    assign data[1] = bus.req2_data_in;
    assign data[2] = bus.req3_data_in;
    assign data[3] = bus.req4_data_in;
    assign tag[0]  = bus.req1_tag_in;
    assign tag[1]  = bus.req2_tag_in;
    assign tag[2]  = bus.req3_tag_in;
    assign tag[3]  = bus.req4_tag_in;

    logic [3:0] head_valid;
    logic [3:0] pop;
    req_t       head [4];

    for (genvar i = 0; i < 4; i++) begin : g_port
        calc2_port u_port (
            .c_clk      (c_clk),
            .reset      (reset),
            .cmd        (cmd[i]),
            .data       (data[i]),
            .tag        (tag[i]),
            .pop        (pop[i]),
            .head_valid (head_valid[i]),
            .head       (head[i])
        );
    end

    // Round-robin: search starts at the port after the last grant.
    logic [1:0] last_q;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       grant_valid;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_q;
        cand        = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!grant_valid && head_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign pop = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;

    result_t result;
    assign result = alu(head[grant_idx]);

    resp_e       resp_q [4];
    logic [31:0] data_q [4];
    logic [1:0]  tag_q  [4];

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            last_q <= 2'd3;
            for (int k = 0; k < 4; k++) begin
                resp_q[k] <= RESP_NONE;
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            // Responses are single-cycle pulses: clear unless re-granted.
            for (int k = 0; k < 4; k++) begin
                resp_q[k] <= RESP_NONE;
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            if (grant_valid) begin
                resp_q[grant_idx] <= result.resp;
                data_q[grant_idx] <= result.data;
                tag_q[grant_idx]  <= head[grant_idx].tag;
                last_q            <= grant_idx;
            end
        end
    end

    assign bus.out_resp1 = resp_q[0];
    assign bus.out_resp2 = resp_q[1];
    assign bus.out_resp3 = resp_q[2];
    assign bus.out_resp4 = resp_q[3];
    assign bus.out_data1 = data_q[0];
    assign bus.out_data2 = data_q[1];
    assign bus.out_data3 = data_q[2];
    assign bus.out_data4 = data_q[3];
    assign bus.out_tag1  = tag_q[0];
    assign bus.out_tag2  = tag_q[1];
    assign bus.out_tag3  = tag_q[2];
    assign bus.out_tag4  = tag_q[3];

endmodule

// File: tb/tb_calc2_top.sv
// tb_calc2_top: self-checking bench for calc2_top.
// A transaction-level model (per-port request queues, round-robin pick, plain
// arithmetic ALU) predicts every output each cycle; directed cases pin the
// model with literal values, then randomized traffic runs against it.
module tb_calc2_top;

    logic c_clk = 1'b0;
    logic reset;

    always #5 c_clk = ~c_clk;

    calc2_if bus ();

    calc2_top dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0]  cmd_drv  [4];
    logic [31:0] data_drv [4];
    logic [1:0]  tag_drv  [4];

    assign bus.req1_cmd_in  = cmd_drv[0];
    assign bus.req2_cmd_in  = cmd_drv[1];
    assign bus.req3_cmd_in  = cmd_drv[2];
    assign bus.req4_cmd_in  = cmd_drv[3];
    assign bus.req1_data_in = data_drv[0];
    assign bus.req2_data_in = data_drv[1];
    assign bus.req3_data_in = data_drv[2];
    assign bus.req4_data_in = data_drv[3];
    assign bus.req1_tag_in  = tag_drv[0];
    assign bus.req2_tag_in  = tag_drv[1];
    assign bus.req3_tag_in  = tag_drv[2];
    assign bus.req4_tag_in  = tag_drv[3];

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } mreq_t;

    mreq_t       pend [4][$];
    mreq_t       part [4];
    bit          in_op2 [4];
    int          last_port;
    logic [1:0]  exp_resp [4];
    logic [31:0] exp_data [4];
    logic [1:0]  exp_tag  [4];

    int checks;
    int failures;

    function automatic logic [1:0] dut_resp(input int p);
        case (p)
            0: return bus.out_resp1;
            1: return bus.out_resp2;
            2: return bus.out_resp3;
            default: return bus.out_resp4;
        endcase
    endfunction

    function automatic logic [31:0] dut_data(input int p);
        case (p)
            0: return bus.out_data1;
            1: return bus.out_data2;
            2: return bus.out_data3;
            default: return bus.out_data4;
        endcase
    endfunction

    function automatic logic [1:0] dut_tag(input int p);
        case (p)
            0: return bus.out_tag1;
            1: return bus.out_tag2;
            2: return bus.out_tag3;
            default: return bus.out_tag4;
        endcase
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_alu(input mreq_t r, output logic [1:0] resp,
                                      output logic [31:0] d);
        longint unsigned s;
        resp = 2'd2;
        d    = 32'd0;
        case (r.cmd)
            4'd1: begin
                s = r.op1;
                s = s + r.op2;
                if (s <= 64'hFFFF_FFFF) begin
                    resp = 2'd1;
                    d    = s[31:0];
                end
            end
            4'd2: begin
                if (r.op1 >= r.op2) begin
                    resp = 2'd1;
                    d    = r.op1 - r.op2;
                end
            end
            4'd5: begin
                resp = 2'd1;
                d    = r.op1 << (r.op2 % 32);
            end
            4'd6: begin
                resp = 2'd1;
                d    = r.op1 >> (r.op2 % 32);
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < 4; p++) begin
            pend[p].delete();
            in_op2[p]   = 1'b0;
            exp_resp[p] = '0;
            exp_data[p] = '0;
            exp_tag[p]  = '0;
        end
        last_port = 3;
    endfunction

    // Predicts the outputs after the coming rising edge from the current inputs.
    function automatic void model_edge();
        bit    arriving [4];
        int    g;
        mreq_t r;
        g = -1;
        for (int p = 0; p < 4; p++) arriving[p] = in_op2[p];
        for (int i = 1; i <= 4; i++) begin
            int q;
            q = (last_port + i) % 4;
            if (g < 0 && (pend[q].size() > 0 || arriving[q])) g = q;
        end
        for (int p = 0; p < 4; p++) begin
            if (arriving[p]) begin
                r     = part[p];
                r.op2 = data_drv[p];
                // A full queue only takes the new request if its head leaves now.
                if (pend[p].size() < 4 || p == g) pend[p].push_back(r);
                in_op2[p] = 1'b0;
            end else if (cmd_drv[p] != 4'd0) begin
                part[p]   = '{cmd: cmd_drv[p], tag: tag_drv[p], op1: data_drv[p], op2: 32'd0};
                in_op2[p] = 1'b1;
            end
            exp_resp[p] = '0;
            exp_data[p] = '0;
            exp_tag[p]  = '0;
        end
        if (g >= 0) begin
            r = pend[g].pop_front();
            model_alu(r, exp_resp[g], exp_data[g]);
            exp_tag[g] = r.tag;
            last_port  = g;
        end
    endfunction

    function automatic void compare_all();
        int active;
        active = 0;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("model_resp%0d", p + 1), dut_resp(p), exp_resp[p]);
            check($sformatf("model_data%0d", p + 1), dut_data(p), exp_data[p]);
            check($sformatf("model_tag%0d", p + 1), dut_tag(p), exp_tag[p]);
            if (dut_resp(p) != 2'd0) active++;
        end
        check("single_active_resp", 32'(active <= 1), 32'd1);
    endfunction

    task automatic tick();
        model_edge();
        @(negedge c_clk);
        compare_all();
    endtask

    task automatic set_idle();
        for (int p = 0; p < 4; p++) begin
            cmd_drv[p]  = '0;
            data_drv[p] = '0;
            tag_drv[p]  = '0;
        end
    endtask

    task automatic lit(input string name, input int p, input logic [1:0] r,
                       input logic [31:0] d, input logic [1:0] t);
        check({name, "_resp"}, dut_resp(p), r);
        check({name, "_data"}, dut_data(p), d);
        check({name, "_tag"}, dut_tag(p), t);
    endtask

    // Leaves the bench at the falling edge inside cycle A+2.
    task automatic issue1(input int p, input logic [3:0] c, input logic [1:0] t,
                          input logic [31:0] op1, input logic [31:0] op2);
        cmd_drv[p]  = c;
        data_drv[p] = op1;
        tag_drv[p]  = t;
        tick();
        cmd_drv[p]  = '0;
        tag_drv[p]  = '0;
        data_drv[p] = op2;
        tick();
        data_drv[p] = '0;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_cmd();
        int k;
        k = $urandom_range(0, 11);
        if (k <= 2) return 4'd1;
        if (k <= 5) return 4'd2;
        if (k <= 7) return 4'd5;
        if (k <= 9) return 4'd6;
        if (k == 10) return 4'd3;
        return 4'($urandom_range(7, 15));
    endfunction

    task automatic issue_all_add();
        for (int p = 0; p < 4; p++) begin
            cmd_drv[p]  = 4'd1;
            data_drv[p] = 32'(p + 1);
            tag_drv[p]  = 2'(p);
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            cmd_drv[p]  = '0;
            tag_drv[p]  = '0;
            data_drv[p] = 32'd10;
        end
        tick();
        set_idle();
        for (int p = 0; p < 4; p++) begin
            lit($sformatf("arb_port%0d", p + 1), p, 2'd1, 32'(p + 11), 2'(p));
            if (p < 3) tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        set_idle();
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge c_clk);
        for (int p = 0; p < 4; p++) lit($sformatf("reset_port%0d", p + 1), p, 2'd0, 0, 2'd0);
        reset = 1'b1;
        tick();

        // Directed cases with literal expectations.
        issue1(0, 4'd1, 2'd1, 32'h30, 32'h20);
        lit("add_p1", 0, 2'd1, 32'h50, 2'd1);
        tick();
        lit("add_p1_after", 0, 2'd0, 32'd0, 2'd0);
        issue1(1, 4'd1, 2'd3, 32'hFFFF_FFFF, 32'd1);
        lit("add_overflow", 1, 2'd2, 32'd0, 2'd3);
        issue1(1, 4'd2, 2'd1, 32'd5, 32'd6);
        lit("sub_underflow", 1, 2'd2, 32'd0, 2'd1);
        issue1(1, 4'd2, 2'd2, 32'd6, 32'd6);
        lit("sub_equal", 1, 2'd1, 32'd0, 2'd2);
        issue1(2, 4'd5, 2'd0, 32'h1, 32'h21);
        lit("shl_masked", 2, 2'd1, 32'h2, 2'd0);
        issue1(2, 4'd6, 2'd1, 32'h8000_0000, 32'd31);
        lit("shr_31", 2, 2'd1, 32'h1, 2'd1);
        issue1(3, 4'd3, 2'd2, 32'd7, 32'd9);
        lit("invalid_cmd", 3, 2'd2, 32'd0, 2'd2);
        repeat (2) tick();

        issue_all_add();
        repeat (2) tick();

        for (int k = 0; k < 4; k++) begin
            cmd_drv[0]  = 4'd1;
            data_drv[0] = 32'(k);
            tag_drv[0]  = 2'(k);
            tick();
            cmd_drv[0]  = '0;
            tag_drv[0]  = '0;
            data_drv[0] = 32'd100;
            tick();
            lit($sformatf("in_order_%0d", k), 0, 2'd1, 32'(k + 100), 2'(k));
        end
        set_idle();
        repeat (2) tick();

        // Randomized traffic, occasionally overrunning a port's FIFO.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 4; p++) begin
                if (in_op2[p]) begin
                    cmd_drv[p]  = '0;
                    tag_drv[p]  = '0;
                    data_drv[p] = rand_op();
                end else if ($urandom_range(0, 99) < 55 &&
                             (pend[p].size() < 4 || $urandom_range(0, 7) == 0)) begin
                    cmd_drv[p]  = rand_cmd();
                    tag_drv[p]  = 2'($urandom);
                    data_drv[p] = rand_op();
                end else begin
                    cmd_drv[p]  = '0;
                    tag_drv[p]  = '0;
                    data_drv[p] = $urandom;
                end
            end
            tick();
        end
        set_idle();
        repeat (30) tick();

        // Reset while port 2 is between its two request cycles.
        cmd_drv[0]  = 4'd1;
        data_drv[0] = 32'd1;
        tag_drv[0]  = 2'd1;
        tick();
        cmd_drv[0]  = '0;
        tag_drv[0]  = '0;
        data_drv[0] = 32'd2;
        cmd_drv[1]  = 4'd1;
        data_drv[1] = 32'd5;
        tag_drv[1]  = 2'd2;
        tick();
        cmd_drv[1]  = '0;
        tag_drv[1]  = '0;
        data_drv[1] = 32'd7;
        lit("pre_reset_p1", 0, 2'd1, 32'd3, 2'd1);
        #1;
        reset = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) lit($sformatf("async_reset_port%0d", p + 1), p, 2'd0, 0, 2'd0);
        model_reset();
        set_idle();
        @(negedge c_clk);
        reset = 1'b1;
        repeat (10) tick();
        lit("no_resp_after_reset", 1, 2'd0, 32'd0, 2'd0);

        // Arbiter pointer must be back at port 4, so port 1 is served first.
        issue_all_add();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
